mapper_config_controller: RTL and testbench

MAPPER_CONFIG_CONTROLLER -- requirements
Module: mapper_config_controller

---
 rtl/mapper_config_controller.sv | 169 ++++++++++++++++
 tb/tb_mapper_config_controller.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mapper_config_controller.sv
// Mapper configuration register block.
// CPU writes to $5000-$5FFF (mirrored every 8 bytes) stage values into a shadow
// copy of every field. A control write (index 7) commits the shadow to the
// outputs and can lock the block. A two-byte key ($A5 then $5A to index 7)
// unlocks it again. Unlocking never commits.
module mapper_config_controller #(
    parameter logic [6:0] RESET_PRG_MASK = 7'h78,
    parameter logic [4:0] RESET_MAPPER   = 5'd0
) (
    input  logic        m2,
    input  logic        reset,
    input  logic        romsel,
    input  logic        cpu_rw_in,
    input  logic [14:0] cpu_addr_in,
    input  logic [7:0]  cpu_data_in,
    output logic [12:0] cpu_base,
    output logic [6:0]  prg_mask,
    output logic [4:0]  chr_mask,
    output logic [1:0]  sram_page,
    output logic [4:0]  flags,
    output logic [4:0]  mapper_select,
    output logic        locked,
    output logic        pending
);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_KEY1     = 2'd2
    } state_t;

    localparam logic [7:0] KEY_FIRST  = 8'hA5;
    localparam logic [7:0] KEY_SECOND = 8'h5A;

    state_t state;
    state_t state_next;

    // Shadow copy of every configurable field.
    logic [12:0] sh_cpu_base;
    logic [6:0]  sh_prg_mask;
    logic [4:0]  sh_chr_mask;
    logic [1:0]  sh_sram_page;
    logic [4:0]  sh_flags;
    logic [4:0]  sh_mapper;

    logic        cfg_wr;
    logic        ctrl_wr;
    logic [2:0]  reg_idx;
    logic        shadow_we;
    logic        commit_en;
    logic        pending_set;

    // Only A2..A0 select a register; A11..A3 are mirrored and deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr_in[11:3];

    assign cfg_wr  = romsel && !cpu_rw_in && (cpu_addr_in[14:12] == 3'b101);
    assign reg_idx = cpu_addr_in[2:0];
    assign ctrl_wr = cfg_wr && (reg_idx == 3'd7);

    assign locked  = (state != ST_UNLOCKED);

    // Lock state register.
    always_ff @(posedge m2 or posedge reset) begin
        if (reset) begin
            state <= ST_UNLOCKED;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus shadow/commit strobes; key writes never act as control writes.
    always_comb begin
        state_next  = state;
        shadow_we   = 1'b0;
        commit_en   = 1'b0;
        pending_set = 1'b0;
        case (state)
            ST_UNLOCKED: begin
                if (cfg_wr && !ctrl_wr) begin
                    shadow_we   = 1'b1;
                    pending_set = 1'b1;
                end
                if (ctrl_wr) begin
                    commit_en = cpu_data_in[0];
                    if (cpu_data_in[7]) begin
                        state_next = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (ctrl_wr && (cpu_data_in == KEY_FIRST)) begin
                    state_next = ST_KEY1;
                end
            end
            ST_KEY1: begin
                if (cfg_wr) begin
                    if (ctrl_wr && (cpu_data_in == KEY_SECOND)) begin
                        state_next = ST_UNLOCKED;
                    end else begin
                        state_next = ST_LOCKED;
                    end
                end
            end
            default: begin
                state_next = ST_UNLOCKED;
            end
        endcase
    end

    // Shadow field updates, one register index per write.
    always_ff @(posedge m2 or posedge reset) begin
        if (reset) begin
            sh_cpu_base  <= 13'd0;
            sh_prg_mask  <= RESET_PRG_MASK;
            sh_chr_mask  <= 5'd0;
            sh_sram_page <= 2'd0;
            sh_flags     <= 5'd0;
            sh_mapper    <= RESET_MAPPER;
        end else if (shadow_we) begin
            case (reg_idx)
                3'd0: sh_cpu_base[12:5] <= cpu_data_in;
                3'd1: sh_cpu_base[4:0]  <= cpu_data_in[4:0];
                3'd2: sh_prg_mask       <= cpu_data_in[6:0];
                3'd3: sh_chr_mask       <= cpu_data_in[4:0];
                3'd4: begin
                    // {four_screen, map_rom_on_6000, sram_enabled} land in flags[2:0].
                    sh_flags[2:0] <= cpu_data_in[4:2];
                    sh_sram_page  <= cpu_data_in[1:0];
                end
                3'd5: sh_flags[4:3]     <= cpu_data_in[1:0];
                3'd6: sh_mapper         <= cpu_data_in[4:0];
                default: begin
                end
            endcase
        end
    end

    // Committed outputs: copied from the shadow on a commit, otherwise held.
    always_ff @(posedge m2 or posedge reset) begin
        if (reset) begin
            cpu_base      <= 13'd0;
            prg_mask      <= RESET_PRG_MASK;
            chr_mask      <= 5'd0;
            sram_page     <= 2'd0;
            flags         <= 5'd0;
            mapper_select <= RESET_MAPPER;
        end else if (commit_en) begin
            cpu_base      <= sh_cpu_base;
            prg_mask      <= sh_prg_mask;
            chr_mask      <= sh_chr_mask;
            sram_page     <= sh_sram_page;
            flags         <= sh_flags;
            mapper_select <= sh_mapper;
        end
    end

    // Pending marks shadow contents that differ from what was last committed.
    always_ff @(posedge m2 or posedge reset) begin
        if (reset) begin
            pending <= 1'b0;
        end else if (commit_en) begin
            pending <= 1'b0;
        end else if (pending_set) begin
            pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mapper_config_controller.sv
// Directed bench for mapper_config_controller.
module tb_mapper_config_controller;

    logic        m2;
    logic        reset;
    logic        romsel;
    logic        cpu_rw_in;
    logic [14:0] cpu_addr_in;
    logic [7:0]  cpu_data_in;
    logic [12:0] cpu_base;
    logic [6:0]  prg_mask;
    logic [4:0]  chr_mask;
    logic [1:0]  sram_page;
    logic [4:0]  flags;
    logic [4:0]  mapper_select;
    logic        locked;
    logic        pending;

    int checks = 0;
    int errors = 0;

    mapper_config_controller dut (
        .m2            (m2),
        .reset         (reset),
        .romsel        (romsel),
        .cpu_rw_in     (cpu_rw_in),
        .cpu_addr_in   (cpu_addr_in),
        .cpu_data_in   (cpu_data_in),
        .cpu_base      (cpu_base),
        .prg_mask      (prg_mask),
        .chr_mask      (chr_mask),
        .sram_page     (sram_page),
        .flags         (flags),
        .mapper_select (mapper_select),
        .locked        (locked),
        .pending       (pending)
    );

    initial m2 = 1'b0;
    always #5 m2 = ~m2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One CPU bus cycle: drive on the falling edge, return 1 time unit after the rising edge.
    task automatic bus(input logic rs, input logic rw, input logic [14:0] addr, input logic [7:0] data);
        @(negedge m2);
        romsel      = rs;
        cpu_rw_in   = rw;
        cpu_addr_in = addr;
        cpu_data_in = data;
        @(posedge m2);
        #1;
    endtask

    task automatic wr(input logic [14:0] addr, input logic [7:0] data);
        bus(1'b1, 1'b0, addr, data);
    endtask

    task automatic idle();
        bus(1'b0, 1'b1, 15'h0000, 8'h00);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cpu_base"}, 32'(cpu_base), 32'h0);
        check({tag, "_prg_mask"}, 32'(prg_mask), 32'h78);
        check({tag, "_chr_mask"}, 32'(chr_mask), 32'h0);
        check({tag, "_sram_page"}, 32'(sram_page), 32'h0);
        check({tag, "_flags"}, 32'(flags), 32'h0);
        check({tag, "_mapper"}, 32'(mapper_select), 32'h0);
        check({tag, "_locked"}, 32'(locked), 32'h0);
        check({tag, "_pending"}, 32'(pending), 32'h0);
    endtask

    initial begin
        reset       = 1'b1;
        romsel      = 1'b0;
        cpu_rw_in   = 1'b1;
        cpu_addr_in = 15'h0000;
        cpu_data_in = 8'h00;
        #12;
        check_reset_values("reset");
        @(negedge m2);
        reset = 1'b0;
        idle();

        // Staged base write, then commit.
        wr(15'h5000, 8'h12);
        check("base_wr0_pending", 32'(pending), 32'h1);
        check("base_wr0_cpu_base", 32'(cpu_base), 32'h0);
        wr(15'h5001, 8'h03);
        check("base_wr1_cpu_base", 32'(cpu_base), 32'h0);
        wr(15'h5007, 8'h01);
        check("commit_cpu_base", 32'(cpu_base), 32'h0243);
        check("commit_pending", 32'(pending), 32'h0);
        check("commit_locked", 32'(locked), 32'h0);

        // Remaining field mapping.
        wr(15'h5003, 8'hFF);
        wr(15'h5004, 8'h1D);
        wr(15'h5005, 8'hFE);
        wr(15'h5006, 8'h25);
        check("fields_staged_chr", 32'(chr_mask), 32'h0);
        check("fields_staged_mapper", 32'(mapper_select), 32'h0);
        wr(15'h5007, 8'h01);
        check("fields_chr_mask", 32'(chr_mask), 32'h1F);
        check("fields_sram_page", 32'(sram_page), 32'h1);
        check("fields_flags", 32'(flags), 32'h17);
        check("fields_mapper", 32'(mapper_select), 32'h05);
        check("fields_cpu_base", 32'(cpu_base), 32'h0243);
        check("fields_prg_mask", 32'(prg_mask), 32'h78);

        // Non-config cycles are ignored.
        wr(15'h5002, 8'h11);
        check("stage_prg_pending", 32'(pending), 32'h1);
        bus(1'b0, 1'b0, 15'h0000, 8'h01);
        wr(15'h4007, 8'h01);
        bus(1'b1, 1'b1, 15'h5007, 8'h01);
        check("ignored_prg_mask", 32'(prg_mask), 32'h78);
        check("ignored_pending", 32'(pending), 32'h1);

        // Commit and lock on one edge, mirrored address.
        wr(15'h5F02, 8'h7F);
        wr(15'h5007, 8'h81);
        check("lockcommit_prg_mask", 32'(prg_mask), 32'h7F);
        check("lockcommit_locked", 32'(locked), 32'h1);
        check("lockcommit_pending", 32'(pending), 32'h0);
        wr(15'h5002, 8'h00);
        wr(15'h5007, 8'h01);
        check("locked_prg_mask", 32'(prg_mask), 32'h7F);
        check("locked_pending", 32'(pending), 32'h0);

        // Key sequence with harmless cycles between the two bytes.
        wr(15'h5007, 8'hA5);
        check("key1_locked", 32'(locked), 32'h1);
        bus(1'b1, 1'b1, 15'h5007, 8'h00);
        wr(15'h6000, 8'h00);
        wr(15'h5007, 8'h5A);
        check("unlock_locked", 32'(locked), 32'h0);
        check("unlock_prg_mask", 32'(prg_mask), 32'h7F);

        // Broken key sequence.
        wr(15'h5007, 8'h80);
        check("relock_locked", 32'(locked), 32'h1);
        wr(15'h5007, 8'hA5);
        wr(15'h5003, 8'h5A);
        check("badkey_locked", 32'(locked), 32'h1);
        wr(15'h5007, 8'h5A);
        check("badkey_second_locked", 32'(locked), 32'h1);
        check("badkey_chr_mask", 32'(chr_mask), 32'h1F);

        // Unlock with pending data does not commit.
        wr(15'h5007, 8'hA5);
        wr(15'h5007, 8'h5A);
        check("unlock2_locked", 32'(locked), 32'h0);
        wr(15'h5006, 8'h0A);
        wr(15'h5007, 8'h80);
        check("lock_nocommit_mapper", 32'(mapper_select), 32'h05);
        check("lock_nocommit_pending", 32'(pending), 32'h1);
        wr(15'h5007, 8'hA5);
        wr(15'h5007, 8'h5A);
        check("unlock_nocommit_mapper", 32'(mapper_select), 32'h05);
        check("unlock_nocommit_pending", 32'(pending), 32'h1);

        // Reset while m2 is high, in KEY1, with pending data.
        wr(15'h5007, 8'h80);
        wr(15'h5007, 8'hA5);
        check("prereset_locked", 32'(locked), 32'h1);
        check("prereset_pending", 32'(pending), 32'h1);
        #1;
        reset = 1'b1;
        #1;
        check_reset_values("async_reset");
        @(negedge m2);
        romsel    = 1'b0;
        cpu_rw_in = 1'b1;
        reset     = 1'b0;
        idle();
        check_reset_values("after_reset");

        // Shadow was discarded: a commit brings back reset values.
        wr(15'h5007, 8'h01);
        check("postreset_commit_mapper", 32'(mapper_select), 32'h0);
        check("postreset_commit_prg_mask", 32'(prg_mask), 32'h78);
        check("postreset_commit_cpu_base", 32'(cpu_base), 32'h0);

        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
